// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_arb_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    WAIT,
    GAP
  } state_t;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester, slave-select and byte-engine signals of the SPI bus arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_bus_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ss_n;
  logic                    eng_start;
  logic [BYTE_W-1:0]       eng_data;
  logic                    eng_done;
  logic                    busy;

  modport master (
    input  req_valid, req_data, req_last, eng_done,
    output req_ready, grant, ss_n, eng_start, eng_data, busy
  );

  modport slave (
    output req_valid, req_data, req_last, eng_done,
    input  req_ready, grant, ss_n, eng_start, eng_data, busy
  );

endinterface

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request scanning from
// ptr+1 upward (mod N_REQ). The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  // cand_idx[k] is the requester examined at scan position k (k=0 first)
  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(ptr) + gi + 1) % N_REQ);
      assign hit[gi]      = req[cand_idx[gi]];
    end
  endgenerate

  // Walk scan positions from last to first so the earliest hit wins
  always_comb begin
    idx = '0;
    gnt = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand_idx[k];
      end
    end
    if (|req) begin
      gnt = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte engine between N_REQ requesters. A round-robin winner
// keeps the bus (and its slave select low) for a whole burst ending on the
// byte flagged last; a minimum deselect gap follows every burst.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic               clk,
  input logic               rst,
  spi_bus_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  gap_cnt_reg, gap_cnt_next;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  req_ready;
  logic              eng_start;
  logic [BYTE_W-1:0] eng_data;

  // Per-requester byte lanes
  logic [BYTE_W-1:0] req_byte [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = bus.req_data[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // State, owner, pointer, last flag and gap counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ptr_reg     <= PTR_RST;
      last_reg    <= 1'b0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      last_reg    <= last_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  // Next-state and handshake outputs; ptr_reg doubles as the owner index
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    last_next    = last_reg;
    gap_cnt_next = gap_cnt_reg;
    req_ready    = '0;
    eng_start    = 1'b0;
    eng_data     = '0;
    case (state_reg)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_next = pick_gnt;
          ptr_next   = pick_idx;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = LOAD;
      end
      LOAD: begin
        if (bus.req_valid[ptr_reg]) begin
          req_ready[ptr_reg] = 1'b1;
          eng_start          = 1'b1;
          eng_data           = req_byte[ptr_reg];
          last_next          = bus.req_last[ptr_reg];
          state_next         = WAIT;
        end
      end
      WAIT: begin
        if (bus.eng_done) begin
          if (last_reg) begin
            state_next   = GAP;
            grant_next   = '0;
            gap_cnt_next = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_next = LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave selects are the inverted grant, so at most one is ever low
  assign bus.grant     = grant_reg;
  assign bus.ss_n      = ~grant_reg;
  assign bus.req_ready = req_ready;
  assign bus.eng_start = eng_start;
  assign bus.eng_data  = eng_data;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: requester queues feed the DUT, a
// scoreboard of expected (owner, byte) pairs is checked on each eng_start,
// and a simple engine model answers each start with eng_done.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int N       = 4;
  localparam int GAP     = 2;
  localparam int ENG_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_bus_arbiter_if #(.N_REQ(N)) bus ();

  spi_bus_arbiter #(
    .N_REQ      (N),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  src_q [N][$];     // {last, data} per requester
  logic [10:0] exp_q [$];        // {owner idx, data} in expected start order
  int          eng_cnt = 0;
  int          hi_run = 0;
  bit          had_burst = 0;
  bit          prev_hi = 1;
  int          n_release = 0;
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic drive();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    logic [8:0]     f;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        f            = src_q[i][0];
        v[i]         = 1'b1;
        d[8*i +: 8]  = f[7:0];
        l[i]         = f[8];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endtask

  task automatic push(input int idx, input logic [7:0] data, input logic last);
    src_q[idx].push_back({last, data});
    exp_q.push_back({3'(idx), data});
  endtask

  function automatic bit all_done();
    bit r;
    r = (bus.busy == 1'b0) && (exp_q.size() == 0);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) r = 1'b0;
    end
    return r;
  endfunction

  // One clock: check at negedge, then advance engine model and inputs after posedge
  task automatic cyc();
    logic [10:0] e;
    @(negedge clk);
    chk("ss_vs_grant", {28'd0, ~bus.ss_n}, {28'd0, bus.grant});
    chk("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
    chk("ready_vs_start", {28'd0, bus.req_ready}, {28'd0, (bus.eng_start ? bus.grant : 4'b0000)});
    if (prev_grant != '0 && bus.grant != '0) begin
      chk("grant_stable", {28'd0, bus.grant}, {28'd0, prev_grant});
    end
    prev_grant = bus.grant;
    if (&bus.ss_n) begin
      hi_run++;
      if (!prev_hi) n_release++;
      prev_hi = 1'b1;
    end else begin
      if (hi_run > 0 && had_burst) begin
        chk("gap_len", (hi_run >= GAP + 1) ? GAP + 1 : hi_run, GAP + 1);
      end
      hi_run    = 0;
      had_burst = 1'b1;
      prev_hi   = 1'b0;
    end
    if (bus.eng_start) begin
      chk("start_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("start: owner=%0d data=%02h", e[10:8], bus.eng_data);
        chk("eng_data", {24'd0, bus.eng_data}, {24'd0, e[7:0]});
        chk("start_owner", {28'd0, bus.grant}, 32'(1) << e[10:8]);
      end
      eng_cnt = ENG_LAT;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    @(posedge clk);
    #1;
    bus.eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) bus.eng_done = 1'b1;
    end
    drive();
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (k < bound && !all_done()) begin
      cyc();
      k++;
    end
    chk("idle_reached", 32'(all_done()), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    eng_cnt      = 0;
    bus.eng_done = 1'b0;
    drive();
    cyc();
    cyc();
    rst        = 1'b0;
    hi_run     = 0;
    had_burst  = 1'b0;
    prev_hi    = 1'b1;
    prev_grant = '0;
  endtask

  initial begin
    int rel0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.eng_done  = 1'b0;

    // Reset state
    do_reset();
    chk("rst_grant", {28'd0, bus.grant}, 0);
    chk("rst_ss_n", {28'd0, bus.ss_n}, 32'hF);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_start", {31'd0, bus.eng_start}, 0);
    chk("rst_ready", {28'd0, bus.req_ready}, 0);
    chk("rst_data", {24'd0, bus.eng_data}, 0);

    // Single byte from requester 0: ss low at t+1, start at t+2
    push(0, 8'hA5, 1'b1);
    drive();
    cyc();
    chk("t1_ss_n", {28'd0, bus.ss_n}, 32'hE);
    chk("t1_grant", {28'd0, bus.grant}, 32'h1);
    chk("t1_busy", {31'd0, bus.busy}, 1);
    chk("t1_no_start_setup", {31'd0, bus.eng_start}, 0);
    cyc();
    chk("t1_start", {31'd0, bus.eng_start}, 1);
    chk("t1_data", {24'd0, bus.eng_data}, 32'hA5);
    chk("t1_ready", {28'd0, bus.req_ready}, 32'h1);
    wait_idle(40);
    chk("t1_ss_release", {28'd0, bus.ss_n}, 32'hF);

    // Spurious eng_done in IDLE
    bus.eng_done = 1'b1;
    cyc();
    chk("idle_done_busy", {31'd0, bus.busy}, 0);
    chk("idle_done_grant", {28'd0, bus.grant}, 0);
    cyc();
    chk("idle_done_busy2", {31'd0, bus.busy}, 0);

    // Three-byte burst from requester 2
    rel0 = n_release;
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    drive();
    wait_idle(80);
    chk("t2_releases", n_release - rel0, 1);
    chk("t2_ss_n", {28'd0, bus.ss_n}, 32'hF);

    // Spurious eng_done in GAP
    push(3, 8'hC3, 1'b1);
    drive();
    for (int k = 0; k < 40 && !(bus.grant == '0 && bus.busy && exp_q.size() == 0); k++) cyc();
    chk("gap_entered", {31'd0, bus.busy}, 1);
    bus.eng_done = 1'b1;
    cyc();
    chk("gap_done_busy", {31'd0, bus.busy}, 1);
    chk("gap_done_grant", {28'd0, bus.grant}, 0);
    chk("gap_done_ready", {28'd0, bus.req_ready}, 0);
    wait_idle(40);

    // Stall: owner 1 drops req_valid after its first byte
    push(1, 8'h4A, 1'b0);
    drive();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cyc();
    chk("stall_first_sent", exp_q.size(), 0);
    repeat (8) cyc();
    chk("stall_grant", {28'd0, bus.grant}, 32'h2);
    chk("stall_ss_n", {28'd0, bus.ss_n}, 32'hD);
    chk("stall_busy", {31'd0, bus.busy}, 1);
    chk("stall_no_start", {31'd0, bus.eng_start}, 0);
    push(1, 8'h5C, 1'b1);
    drive();
    #1;
    chk("unstall_start", {31'd0, bus.eng_start}, 1);
    chk("unstall_data", {24'd0, bus.eng_data}, 32'h5C);
    chk("unstall_ready", {28'd0, bus.req_ready}, 32'h2);
    wait_idle(40);

    // Round-robin with requesters 0,1,3 valid: order 0,1,3,0,1
    do_reset();
    rel0 = n_release;
    push(0, 8'h01, 1'b1);
    push(1, 8'h02, 1'b1);
    push(3, 8'h04, 1'b1);
    push(0, 8'h05, 1'b1);
    push(1, 8'h06, 1'b1);
    drive();
    wait_idle(200);
    chk("rr_releases", n_release - rel0, 5);

    // Reset during WAIT of byte 2 of a 3-byte burst
    push(1, 8'h71, 1'b0);
    push(1, 8'h72, 1'b0);
    push(1, 8'h73, 1'b1);
    drive();
    for (int k = 0; k < 60 && exp_q.size() > 1; k++) cyc();
    chk("mid_two_started", exp_q.size(), 1);
    chk("mid_owner", {28'd0, bus.grant}, 32'h2);
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    cyc();
    chk("mid_rst_ss_n", {28'd0, bus.ss_n}, 32'hF);
    chk("mid_rst_grant", {28'd0, bus.grant}, 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    rst        = 1'b0;
    hi_run     = 0;
    had_burst  = 1'b0;
    prev_hi    = 1'b1;
    prev_grant = '0;
    repeat (5) cyc();
    chk("post_rst_idle", {31'd0, bus.busy}, 0);
    push(0, 8'hE0, 1'b1);
    push(2, 8'hE2, 1'b1);
    drive();
    wait_idle(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
